// File: rtl/bus_arbiter_if.sv
// Bus arbiter signal bundle: requester handshakes (CPU, DMA) and external bus pins.
// The arbiter uses the master view; requesters, pads and memory use the slave view.
interface bus_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) ();
    // CPU requester
    logic          cpu_req;
    logic          cpu_rnw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_done;

    // DMA requester
    logic          dma_req;
    logic          dma_rnw;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_done;

    // Shared completion status
    logic [DW-1:0] rdata;
    logic          err;

    // External multiplexed bus
    logic [DW-1:0] data_out;
    logic          enb;
    logic          n_me;
    logic          ale;
    logic          rnw;
    logic          n_oe;
    logic [DW-1:0] data_in;
    logic          n_wait;

    modport master (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done,
        input  dma_req, dma_rnw, dma_addr, dma_wdata,
        output dma_gnt, dma_done,
        output rdata, err,
        output data_out, enb, n_me, ale, rnw, n_oe,
        input  data_in, n_wait
    );

    modport slave (
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done,
        output dma_req, dma_rnw, dma_addr, dma_wdata,
        input  dma_gnt, dma_done,
        input  rdata, err,
        input  data_out, enb, n_me, ale, rnw, n_oe,
        output data_in, n_wait
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port (CPU / DMA) round-robin arbiter for a multiplexed address/data bus.
// Each bus cycle runs IDLE -> ADDR -> DATA (wait states) -> END; all outputs registered.
module bus_arbiter #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StEnd} state_e;

    state_e        state;
    logic          owner_dma;  // 1 when the current cycle belongs to the DMA port
    logic          last_dma;   // 1 when the DMA port was served last
    logic          lat_rnw;
    logic [DW-1:0] lat_wdata;
    logic [CntW-1:0] wait_cnt;

    logic          win_dma;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_rnw;
    logic [CntW-1:0] cnt_inc;
    logic          timeout;
    logic          finish;

    // Arbitration winner, wait counter increment and data-phase exit conditions
    always_comb begin
        // Sole requester wins; on a tie the port not served last wins
        win_dma   = bus.dma_req && (!bus.cpu_req || !last_dma);
        win_addr  = win_dma ? bus.dma_addr  : bus.cpu_addr;
        win_wdata = win_dma ? bus.dma_wdata : bus.cpu_wdata;
        win_rnw   = win_dma ? bus.dma_rnw   : bus.cpu_rnw;
        cnt_inc   = wait_cnt + CntW'(1);
        timeout   = (WAIT_MAX != 0) && !bus.n_wait && (cnt_inc == CntW'(WAIT_MAX));
        finish    = bus.n_wait || timeout;
    end

    // Bus-cycle FSM with registered strobes, grants and completion status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            owner_dma    <= 1'b0;
            last_dma     <= 1'b1;
            lat_rnw      <= 1'b1;
            lat_wdata    <= '0;
            wait_cnt     <= '0;
            bus.cpu_gnt  <= 1'b0;
            bus.cpu_done <= 1'b0;
            bus.dma_gnt  <= 1'b0;
            bus.dma_done <= 1'b0;
            bus.rdata    <= '0;
            bus.err      <= 1'b0;
            bus.data_out <= '0;
            bus.enb      <= 1'b0;
            bus.n_me     <= 1'b1;
            bus.ale      <= 1'b0;
            bus.rnw      <= 1'b1;
            bus.n_oe     <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        owner_dma    <= win_dma;
                        last_dma     <= win_dma;
                        lat_rnw      <= win_rnw;
                        lat_wdata    <= win_wdata;
                        bus.cpu_gnt  <= !win_dma;
                        bus.dma_gnt  <= win_dma;
                        // Outputs for the ADDR clock are loaded on the way in
                        bus.n_me     <= 1'b0;
                        bus.ale      <= 1'b1;
                        bus.enb      <= 1'b1;
                        bus.data_out <= DW'(win_addr);
                        bus.rnw      <= win_rnw;
                        state        <= StAddr;
                    end
                end
                StAddr: begin
                    bus.ale <= 1'b0;
                    if (lat_rnw) begin
                        bus.enb  <= 1'b0;
                        bus.n_oe <= 1'b0;
                    end else begin
                        bus.enb      <= 1'b1;
                        bus.data_out <= lat_wdata;
                        bus.n_oe     <= 1'b1;
                    end
                    state <= StData;
                end
                StData: begin
                    if (!bus.n_wait) begin
                        wait_cnt <= cnt_inc;
                    end
                    if (bus.n_wait && lat_rnw) begin
                        bus.rdata <= bus.data_in;
                    end
                    if (finish) begin
                        bus.n_me     <= 1'b1;
                        bus.n_oe     <= 1'b1;
                        bus.enb      <= 1'b0;
                        bus.rnw      <= 1'b1;
                        bus.cpu_done <= !owner_dma;
                        bus.dma_done <= owner_dma;
                        bus.err      <= !bus.n_wait;
                        state        <= StEnd;
                    end
                end
                StEnd: begin
                    bus.cpu_done <= 1'b0;
                    bus.dma_done <= 1'b0;
                    bus.err      <= 1'b0;
                    bus.cpu_gnt  <= 1'b0;
                    bus.dma_gnt  <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed cycles plus a completion scoreboard.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_arbiter_if #(.AW(16), .DW(16)) bif ();
    bus_arbiter_if #(.AW(16), .DW(16)) bif0 ();

    bus_arbiter #(.WAIT_MAX(15), .AW(16), .DW(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Same design with the timeout disabled
    bus_arbiter #(.WAIT_MAX(0), .AW(16), .DW(16)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bif0)
    );

    typedef struct packed {
        logic        who;    // 0 = CPU, 1 = DMA
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.cpu_req = 0; bif.cpu_rnw = 1; bif.cpu_addr = '0; bif.cpu_wdata = '0;
        bif.dma_req = 0; bif.dma_rnw = 1; bif.dma_addr = '0; bif.dma_wdata = '0;
        bif.data_in = '0; bif.n_wait = 1;
        bif0.cpu_req = 0; bif0.cpu_rnw = 1; bif0.cpu_addr = '0; bif0.cpu_wdata = '0;
        bif0.dma_req = 0; bif0.dma_rnw = 1; bif0.dma_addr = '0; bif0.dma_wdata = '0;
        bif0.data_in = '0; bif0.n_wait = 1;
    endtask

    // Ticks until a Done is seen, at most max_t clocks; returns the tick count (0 = none)
    task automatic wait_done(input int max_t, output int t_done);
        t_done = 0;
        for (int t = 1; t <= max_t; t++) begin
            tick();
            if (bif.cpu_done || bif.dma_done) begin
                t_done = t;
                break;
            end
        end
    endtask

    function automatic exp_t mk(input logic who, input logic err, input logic [15:0] rd);
        exp_t e;
        e.who = who; e.err = err; e.rdata = rd;
        return e;
    endfunction

    // Scoreboard: every completion is matched against the oldest expected result
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (!rst && (bif.cpu_done || bif.dma_done)) begin
            check_eq("done_onehot", 32'(bif.cpu_done & bif.dma_done), 0);
            check_eq("gnt_excl", 32'(bif.cpu_gnt & bif.dma_gnt), 0);
            check_eq("done_gnt", 32'(bif.dma_done ? bif.dma_gnt : bif.cpu_gnt), 1);
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_who", 32'(bif.dma_done), 32'(e.who));
                check_eq("sb_err", 32'(bif.err), 32'(e.err));
                check_eq("sb_rdata", 32'(bif.rdata), 32'(e.rdata));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int td;
        int zero_dones;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state
        check_eq("rst_n_me", 32'(bif.n_me), 1);
        check_eq("rst_n_oe", 32'(bif.n_oe), 1);
        check_eq("rst_rnw", 32'(bif.rnw), 1);
        check_eq("rst_ale", 32'(bif.ale), 0);
        check_eq("rst_enb", 32'(bif.enb), 0);
        check_eq("rst_data_out", 32'(bif.data_out), 0);
        check_eq("rst_rdata", 32'(bif.rdata), 0);
        check_eq("rst_gnt", 32'({bif.cpu_gnt, bif.dma_gnt}), 0);
        check_eq("rst_done_err", 32'({bif.cpu_done, bif.dma_done, bif.err}), 0);
        rst = 1'b0;

        // Reset in the middle of a stalled DMA write
        bif.dma_req = 1; bif.dma_rnw = 0; bif.dma_addr = 16'h0040; bif.dma_wdata = 16'h00A5;
        bif.n_wait = 0;
        tick();
        check_eq("r_addr_dma_gnt", 32'(bif.dma_gnt), 1);
        tick();
        check_eq("r_data_enb", 32'(bif.enb), 1);
        check_eq("r_data_out", 32'(bif.data_out), 32'h00A5);
        tick();
        #2 rst = 1'b1;
        #1;
        check_eq("r_async_n_me", 32'(bif.n_me), 1);
        check_eq("r_async_enb", 32'(bif.enb), 0);
        check_eq("r_async_dma_gnt", 32'(bif.dma_gnt), 0);
        idle_inputs();
        tick();
        rst = 1'b0;

        // CPU read, zero wait states
        bif.cpu_req = 1; bif.cpu_rnw = 1; bif.cpu_addr = 16'h1234; bif.data_in = 16'hBEEF;
        sb_q.push_back(mk(1'b0, 1'b0, 16'hBEEF));
        tick();
        check_eq("rd_first_gnt", 32'({bif.cpu_gnt, bif.dma_gnt}), 32'b10);
        check_eq("rd_addr_ale", 32'(bif.ale), 1);
        check_eq("rd_addr_bus", 32'(bif.data_out), 32'h1234);
        check_eq("rd_addr_strobes", 32'({bif.n_me, bif.enb, bif.rnw}), 32'b011);
        tick();
        check_eq("rd_data_ale", 32'(bif.ale), 0);
        check_eq("rd_data_strobes", 32'({bif.n_me, bif.n_oe, bif.enb}), 32'b000);
        tick();
        check_eq("rd_end_done", 32'(bif.cpu_done), 1);
        check_eq("rd_end_strobes", 32'({bif.n_me, bif.n_oe, bif.rnw}), 32'b111);
        bif.cpu_req = 0;
        tick();
        check_eq("rd_idle_gnt_done", 32'({bif.cpu_gnt, bif.cpu_done}), 0);

        // DMA write with four wait states
        bif.dma_req = 1; bif.dma_rnw = 0; bif.dma_addr = 16'h0040; bif.dma_wdata = 16'h00A5;
        bif.n_wait = 0;
        sb_q.push_back(mk(1'b1, 1'b0, 16'hBEEF));
        tick();
        check_eq("wr_addr_bus", 32'(bif.data_out), 32'h0040);
        check_eq("wr_addr_rnw", 32'(bif.rnw), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("wr_wait_bus", 32'({bif.enb, bif.n_oe, bif.data_out}), 32'h300A5);
            check_eq("wr_wait_done_cgnt", 32'({bif.dma_done, bif.cpu_gnt}), 0);
            tick();
        end
        check_eq("wr_stall_data", 32'({bif.enb, bif.dma_done}), 32'b10);
        bif.n_wait = 1; bif.dma_req = 0;
        tick();
        check_eq("wr_end_done", 32'({bif.dma_done, bif.cpu_gnt}), 32'b10);
        tick();

        // Both requesting: strict alternation, one transfer per four clocks
        bif.cpu_req = 1; bif.cpu_rnw = 1; bif.cpu_addr = 16'h0100; bif.data_in = 16'h5A5A;
        bif.dma_req = 1; bif.dma_rnw = 0; bif.dma_addr = 16'h0200; bif.dma_wdata = 16'h3C3C;
        sb_q.push_back(mk(1'b0, 1'b0, 16'h5A5A));
        sb_q.push_back(mk(1'b1, 1'b0, 16'h5A5A));
        sb_q.push_back(mk(1'b0, 1'b0, 16'h5A5A));
        sb_q.push_back(mk(1'b1, 1'b0, 16'h5A5A));
        wait_done(20, td);
        check_eq("rr_lat0", td, 3);
        for (int i = 0; i < 3; i++) begin
            wait_done(20, td);
            check_eq("rr_period", td, 4);
        end
        bif.cpu_req = 0; bif.dma_req = 0;
        tick();

        // CPU read timing out after WAIT_MAX wait clocks
        bif.cpu_req = 1; bif.cpu_rnw = 1; bif.cpu_addr = 16'h0400; bif.data_in = 16'hDEAD;
        bif.n_wait = 0;
        sb_q.push_back(mk(1'b0, 1'b1, 16'h5A5A));
        wait_done(40, td);
        check_eq("to_latency", td, 17);
        check_eq("to_err", 32'({bif.cpu_done, bif.err}), 32'b11);
        bif.cpu_req = 0; bif.n_wait = 1;
        tick();

        // Timeout disabled: only nWait ends the cycle
        bif0.cpu_req = 1; bif0.cpu_rnw = 1; bif0.cpu_addr = 16'h0050; bif0.data_in = 16'h0C0C;
        bif0.n_wait = 0;
        zero_dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif0.cpu_done) zero_dones++;
        end
        check_eq("nto_no_done", zero_dones, 0);
        check_eq("nto_still_data", 32'({bif0.cpu_gnt, bif0.n_oe}), 32'b10);
        bif0.n_wait = 1;
        tick();
        check_eq("nto_done", 32'({bif0.cpu_done, bif0.err}), 32'b10);
        check_eq("nto_rdata", 32'(bif0.rdata), 32'h0C0C);
        bif0.cpu_req = 0;
        tick();

        // CPU write with request and inputs changed right after grant
        bif.cpu_req = 1; bif.cpu_rnw = 0; bif.cpu_addr = 16'h0300; bif.cpu_wdata = 16'h7777;
        sb_q.push_back(mk(1'b0, 1'b0, 16'h5A5A));
        tick();
        check_eq("drop_addr_bus", 32'(bif.data_out), 32'h0300);
        bif.cpu_req = 0; bif.cpu_rnw = 1; bif.cpu_addr = 16'hFFFF; bif.cpu_wdata = 16'h0000;
        tick();
        check_eq("drop_data_bus", 32'({bif.enb, bif.n_oe, bif.data_out}), 32'h37777);
        tick();
        check_eq("drop_done", 32'(bif.cpu_done), 1);
        tick();
        tick();
        check_eq("drop_idle", 32'({bif.n_me, bif.cpu_gnt, bif.ale}), 32'b100);

        check_eq("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
